// File: rtl/led_bar_meter.sv
// led_bar_meter
//   Bar-graph driver: turns a score/level value into an N_LEDS meter with
//   instant attack, timed one-LED-at-a-time decay, an optional peak-hold
//   marker and an optional full-scale blink. All outputs are registered.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high; clears every register
//   en        sample strobe; value is captured on an edge where en=1
//   value     raw level, lit count = min(value >> SHIFT, N_LEDS)
//   hold_en   show the peak marker above the bar
//   blink_en  blank the whole bar on alternate phases while at full scale
//   led       LED drive, bit 0 = lowest LED
//   level     current bar length
//   at_max    level == N_LEDS
module led_bar_meter #(
  parameter int VAL_W        = 6,
  parameter int N_LEDS       = 8,
  parameter int SHIFT        = 1,
  parameter int DECAY_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES  = 12_000_000,
  parameter int BLINK_CYCLES = 6_000_000,
  parameter int LW           = $clog2(N_LEDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [VAL_W-1:0]  value,
  input  logic              hold_en,
  input  logic              blink_en,
  output logic [N_LEDS-1:0] led,
  output logic [LW-1:0]     level,
  output logic              at_max
);

  localparam int DW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [LW-1:0] N_L  = LW'(N_LEDS);
  localparam logic [DW-1:0] D_TC = DW'(DECAY_CYCLES - 1);
  localparam logic [HW-1:0] H_TC = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] B_TC = BW'(BLINK_CYCLES - 1);

  // Shift first, then saturate to the number of LEDs.
  function automatic logic [LW-1:0] clamp_tgt(input logic [VAL_W-1:0] v);
    logic [VAL_W-1:0] sh;
    sh = v >> SHIFT;
    if (32'(sh) > 32'(N_LEDS)) clamp_tgt = N_L;
    else                       clamp_tgt = LW'(sh);
  endfunction

  // One-step decrement that never goes below the given floor.
  function automatic logic [LW-1:0] dec_floor(input logic [LW-1:0] x,
                                              input logic [LW-1:0] floor_v);
    if (x > floor_v) dec_floor = x - LW'(1);
    else             dec_floor = floor_v;
  endfunction

  logic [LW-1:0]     tgt_q,    tgt_d;
  logic [LW-1:0]     level_q,  level_d;
  logic [DW-1:0]     dcnt_q,   dcnt_d;
  logic [LW-1:0]     peak_q,   peak_d;
  logic [HW-1:0]     hcnt_q,   hcnt_d;
  logic [BW-1:0]     bcnt_q,   bcnt_d;
  logic              phase_q,  phase_d;
  logic              at_max_q, at_max_d;
  logic [N_LEDS-1:0] led_q,    led_d;
  logic [LW-1:0]     tgt_new;

  always_comb begin
    tgt_new  = clamp_tgt(value);
    tgt_d    = en ? tgt_new : tgt_q;
    level_d  = level_q;
    dcnt_d   = dcnt_q;
    peak_d   = peak_q;
    hcnt_d   = hcnt_q;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    at_max_d = 1'b0;
    led_d    = '0;

    // Bar: attack wins over a coincident decay step. The decay counter only
    // runs once the registered target is below the bar, so the first fall
    // lands DECAY_CYCLES clocks after the bar starts exceeding its target;
    // a coincident step is floored by the freshly sampled target.
    if (en && (tgt_new >= level_q)) begin
      level_d = tgt_new;
      dcnt_d  = '0;
    end else if (level_q > tgt_q) begin
      if (dcnt_q == D_TC) begin
        level_d = dec_floor(level_q, tgt_d);
        dcnt_d  = '0;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end else begin
      dcnt_d = '0;
    end

    // Peak: jumps up with the bar; otherwise the hold counter free-runs and
    // each terminal count lets the peak fall one LED, never below the bar.
    if (level_d > peak_q) begin
      peak_d = level_d;
      hcnt_d = '0;
    end else if (hcnt_q == H_TC) begin
      peak_d = dec_floor(peak_q, level_d);
      hcnt_d = '0;
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end

    // Blink phase advances only while the registered bar is at full scale,
    // so full scale always shows lit for a whole half-period first.
    at_max_d = (level_d == N_L);
    if (!at_max_q) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bcnt_q == B_TC) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d = bcnt_q + BW'(1);
    end

    // LED composition from next-state values so led lines up with level.
    for (int i = 0; i < N_LEDS; i++) begin
      if (LW'(i) < level_d) led_d[i] = 1'b1;
      if (hold_en && (peak_d > level_d) && (peak_d == LW'(i + 1))) led_d[i] = 1'b1;
    end
    if (blink_en && at_max_d && phase_d) led_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_q    <= '0;
      level_q  <= '0;
      dcnt_q   <= '0;
      peak_q   <= '0;
      hcnt_q   <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
      at_max_q <= 1'b0;
      led_q    <= '0;
    end else begin
      tgt_q    <= tgt_d;
      level_q  <= level_d;
      dcnt_q   <= dcnt_d;
      peak_q   <= peak_d;
      hcnt_q   <= hcnt_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      at_max_q <= at_max_d;
      led_q    <= led_d;
    end
  end

  assign led    = led_q;
  assign level  = level_q;
  assign at_max = at_max_q;

endmodule

// File: tb/tb_led_bar_meter.sv
// Scoreboard bench for led_bar_meter with short timing parameters.
// The driver pushes the hand-computed output expected after each clock edge;
// a monitor pops one entry per clock on the falling edge and compares.
module tb_led_bar_meter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [5:0] value = '0;
  logic       hold_en = 1'b0;
  logic       blink_en = 1'b0;
  logic [7:0] led;
  logic [3:0] level;
  logic       at_max;

  led_bar_meter #(
    .VAL_W(6), .N_LEDS(8), .SHIFT(1),
    .DECAY_CYCLES(4), .HOLD_CYCLES(8), .BLINK_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .value(value),
    .hold_en(hold_en), .blink_en(blink_en),
    .led(led), .level(level), .at_max(at_max)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] led;
    logic [3:0] level;
    logic       at_max;
    string      name;
  } exp_t;

  exp_t  sb[$];
  exp_t  mx;
  int    n_tests = 0;
  int    n_fail  = 0;
  string tname   = "init";

  task automatic push(input logic [7:0] el, input logic [3:0] ell);
    exp_t x;
    x.led    = el;
    x.level  = ell;
    x.at_max = (ell == 4'd8);
    x.name   = tname;
    sb.push_back(x);
  endtask

  task automatic step(input logic e, input logic [5:0] v,
                      input logic [7:0] el, input logic [3:0] ell);
    @(negedge clk); #1;
    reset = 1'b0; en = e; value = v;
    push(el, ell);
  endtask

  // Reset with en high and full-scale value: reset must dominate.
  task automatic reset_step(input logic h, input logic b);
    @(negedge clk); #1;
    reset = 1'b1; en = 1'b1; value = 6'd63;
    hold_en = h; blink_en = b;
    push(8'h00, 4'd0);
  endtask

  // Idle cycles drive a garbage value that must be ignored while en=0.
  task automatic idle(input int n, input logic [7:0] el, input logic [3:0] ell);
    for (int i = 0; i < n; i++) step(1'b0, 6'd63, el, ell);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mx = sb.pop_front();
        n_tests++;
        if (led !== mx.led) begin
          n_fail++;
          $display("FAIL %s led: got %02h expected %02h", mx.name, led, mx.led);
        end
        n_tests++;
        if (level !== mx.level) begin
          n_fail++;
          $display("FAIL %s level: got %0d expected %0d", mx.name, level, mx.level);
        end
        n_tests++;
        if (at_max !== mx.at_max) begin
          n_fail++;
          $display("FAIL %s at_max: got %0b expected %0b", mx.name, at_max, mx.at_max);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d entries pending", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    // Attack mapping
    tname = "attack";
    reset_step(1'b0, 1'b0);
    step(1'b1, 6'd0,  8'h00, 4'd0);
    step(1'b1, 6'd1,  8'h00, 4'd0);
    step(1'b1, 6'd5,  8'h03, 4'd2);
    step(1'b1, 6'd17, 8'hFF, 4'd8);
    step(1'b1, 6'd63, 8'hFF, 4'd8);
    step(1'b0, 6'd0,  8'hFF, 4'd8);

    // Decay 8 -> 4 without peak marker
    tname = "decay";
    reset_step(1'b0, 1'b0);
    step(1'b1, 6'd16, 8'hFF, 4'd8);
    step(1'b1, 6'd8,  8'hFF, 4'd8);
    idle(3, 8'hFF, 4'd8);
    idle(4, 8'h7F, 4'd7);
    idle(4, 8'h3F, 4'd6);
    idle(4, 8'h1F, 4'd5);
    idle(6, 8'h0F, 4'd4);

    // Same decay with the peak marker shown
    tname = "peak_hold";
    reset_step(1'b1, 1'b0);
    step(1'b1, 6'd16, 8'hFF, 4'd8);
    step(1'b1, 6'd8,  8'hFF, 4'd8);
    idle(3, 8'hFF, 4'd8);
    idle(3, 8'hFF, 4'd7);
    idle(1, 8'h7F, 4'd7);
    idle(4, 8'h7F, 4'd6);
    idle(3, 8'h5F, 4'd5);
    idle(1, 8'h3F, 4'd5);
    idle(7, 8'h2F, 4'd4);
    idle(8, 8'h1F, 4'd4);
    idle(3, 8'h0F, 4'd4);

    // Full-scale blink, then leave full scale
    tname = "blink";
    reset_step(1'b0, 1'b1);
    step(1'b1, 6'd16, 8'hFF, 4'd8);
    idle(1, 8'hFF, 4'd8);
    idle(2, 8'h00, 4'd8);
    idle(2, 8'hFF, 4'd8);
    idle(2, 8'h00, 4'd8);
    step(1'b1, 6'd14, 8'hFF, 4'd8);
    idle(1, 8'hFF, 4'd8);
    idle(2, 8'h00, 4'd8);
    idle(3, 8'h7F, 4'd7);

    // en with lower target on the decay terminal count
    tname = "coinc_decay";
    reset_step(1'b0, 1'b0);
    step(1'b1, 6'd6, 8'h07, 4'd3);
    step(1'b1, 6'd0, 8'h07, 4'd3);
    idle(3, 8'h07, 4'd3);
    step(1'b1, 6'd2, 8'h03, 4'd2);
    idle(3, 8'h03, 4'd2);
    idle(3, 8'h01, 4'd1);

    // en with higher target on the decay terminal count
    tname = "coinc_attack";
    reset_step(1'b0, 1'b0);
    step(1'b1, 6'd6,  8'h07, 4'd3);
    step(1'b1, 6'd0,  8'h07, 4'd3);
    idle(3, 8'h07, 4'd3);
    step(1'b1, 6'd10, 8'h1F, 4'd5);
    idle(6, 8'h1F, 4'd5);

    // Reset in the middle of a decay; peak must be gone afterwards
    tname = "mid_reset";
    reset_step(1'b0, 1'b0);
    step(1'b1, 6'd16, 8'hFF, 4'd8);
    step(1'b1, 6'd0,  8'hFF, 4'd8);
    idle(3, 8'hFF, 4'd8);
    idle(4, 8'h7F, 4'd7);
    idle(1, 8'h3F, 4'd6);
    reset_step(1'b1, 1'b0);
    idle(4, 8'h00, 4'd0);

    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries never checked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
